// File: rtl/vram_port_arbiter.sv
// Two-requester arbiter for port A of the videocard frame RAM, with read-data routing by owner tag.
// Optional macro SCANOUT_PRIORITY_EN gives requester 1 (scanout) strict priority over the core.
module vram_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int AW           = 16,
  parameter int READ_LATENCY = 2,
  parameter int BURST_MAX    = 16
) (
  input  logic             clk,
  input  logic             reset_sink_reset_n,
  input  logic             req0,
  input  logic             lock0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             wren0,
  output logic             gnt0,
  output logic             rvalid0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             lock1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             wren1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata1,
  output logic [AW-1:0]    ram_address,
  output logic [WIDTH-1:0] ram_data,
  output logic             ram_wren,
  input  logic [WIDTH-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX - 1);

  state_t                  state, state_next;
  logic                    last_owner;
  logic [CW-1:0]           burst_cnt;
  logic [READ_LATENCY-1:0] valid_pipe;
  logic [READ_LATENCY-1:0] tag_pipe;
  logic                    issue0, issue1, issue_read;

  assign gnt0       = (state == OWN0);
  assign gnt1       = (state == OWN1);
  assign issue0     = req0 & gnt0;
  assign issue1     = req1 & gnt1;
  assign issue_read = (issue0 & ~wren0) | (issue1 & ~wren1);

  // RAM port mux: an idle port is driven to all zeros rather than holding the last access
  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (issue0) begin
      ram_address = addr0;
      ram_data    = wdata0;
      ram_wren    = wren0;
    end else if (issue1) begin
      ram_address = addr1;
      ram_data    = wdata1;
      ram_wren    = wren1;
    end
  end

  // Next owner, decided from the registered state so a grant never follows req combinationally
  always_comb begin
    state_next = state;
`ifdef SCANOUT_PRIORITY_EN
    case (state)
      IDLE, OWN0, OWN1: begin
        if (req1)      state_next = OWN1;
        else if (req0) state_next = OWN0;
        else           state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
`else
    case (state)
      IDLE: begin
        if (req0 && req1) state_next = last_owner ? OWN0 : OWN1;
        else if (req0)    state_next = OWN0;
        else if (req1)    state_next = OWN1;
        else              state_next = IDLE;
      end
      OWN0: begin
        if (req0 && (!req1 || (lock0 && burst_cnt < BURST_LAST))) state_next = OWN0;
        else if (req1) state_next = OWN1;
        else           state_next = IDLE;
      end
      OWN1: begin
        if (req1 && (!req0 || (lock1 && burst_cnt < BURST_LAST))) state_next = OWN1;
        else if (req0) state_next = OWN0;
        else           state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
`endif
  end

  // Ownership register; burst_cnt saturates so a lone locked owner yields as soon as the other asks
  always_ff @(posedge clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      state <= state_next;
      if (state_next == OWN0)      last_owner <= 1'b0;
      else if (state_next == OWN1) last_owner <= 1'b1;
      if (state_next != state)
        burst_cnt <= '0;
      else if ((issue0 || issue1) && burst_cnt < BURST_LAST)
        burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Read-return pipeline carries the issuer tag so returns survive ownership changes
  always_ff @(posedge clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      valid_pipe <= '0;
      tag_pipe   <= '0;
    end else begin
      valid_pipe[0] <= issue_read;
      tag_pipe[0]   <= issue1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        tag_pipe[i]   <= tag_pipe[i-1];
      end
    end
  end

  assign rvalid0 = valid_pipe[READ_LATENCY-1] & ~tag_pipe[READ_LATENCY-1];
  assign rvalid1 = valid_pipe[READ_LATENCY-1] &  tag_pipe[READ_LATENCY-1];
  assign rdata0  = ram_q;
  assign rdata1  = ram_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a two-cycle-latency RAM model on port A.
// Unwritten RAM words read back as {16'hC0DE, address} so returned data identifies the address.
module tb_vram_port_arbiter;

  localparam int WIDTH = 32;
  localparam int AW    = 16;

  logic             clk = 1'b0;
  logic             reset_sink_reset_n;
  logic             req0, lock0, wren0, req1, lock1, wren1;
  logic [AW-1:0]    addr0, addr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             gnt0, gnt1, rvalid0, rvalid1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic [AW-1:0]    ram_address;
  logic [WIDTH-1:0] ram_data;
  logic             ram_wren;
  logic [WIDTH-1:0] ram_q = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vram_port_arbiter #(.WIDTH(WIDTH), .AW(AW), .READ_LATENCY(2), .BURST_MAX(16)) dut (
    .clk(clk), .reset_sink_reset_n(reset_sink_reset_n),
    .req0(req0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0), .wren0(wren0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1), .wren1(wren1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // RAM port A model: address registered, then output registered (two cycles to ram_q)
  logic [WIDTH-1:0] mem     [0:65535];
  bit               written [0:65535];
  logic [AW-1:0]    addr_d1 = '0;

  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_address]     <= ram_data;
      written[ram_address] <= 1'b1;
    end
    addr_d1 <= ram_address;
    ram_q   <= written[addr_d1] ? mem[addr_d1] : {16'hC0DE, addr_d1};
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int who, input logic req, input logic lock,
                               input logic [AW-1:0] addr, input logic [WIDTH-1:0] wdata,
                               input logic wren);
    if (who == 0) begin
      req0 = req; lock0 = lock; addr0 = addr; wdata0 = wdata; wren0 = wren;
    end else begin
      req1 = req; lock1 = lock; addr1 = addr; wdata1 = wdata; wren1 = wren;
    end
  endtask

  task automatic idleAll();
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    idleAll();
    reset_sink_reset_n = 1'b0;
    repeat (2) nextCycle();
    reset_sink_reset_n = 1'b1;
  endtask

  initial begin
    idleAll();
    reset_sink_reset_n = 1'b0;
    #2;
    checkOutput("rst gnt0", gnt0, 0);
    checkOutput("rst gnt1", gnt1, 0);
    checkOutput("rst rvalid0", rvalid0, 0);
    checkOutput("rst rvalid1", rvalid1, 0);
    checkOutput("rst ram_wren", ram_wren, 0);
    checkOutput("rst ram_address", ram_address, 0);
    checkOutput("rst ram_data", ram_data, 0);
    repeat (2) nextCycle();
    reset_sink_reset_n = 1'b1;

    // Single read by requester 0
    $display("[TB] single read");
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 16'h0010, '0, 1'b0);
    #1;
    checkOutput("t1 gnt0 idle", gnt0, 0);
    checkOutput("t1 addr idle", ram_address, 0);
    nextCycle(); #1;
    checkOutput("t1 gnt0", gnt0, 1);
    checkOutput("t1 gnt1", gnt1, 0);
    checkOutput("t1 addr", ram_address, 32'h0010);
    checkOutput("t1 wren", ram_wren, 0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    checkOutput("t1 rvalid0 early", rvalid0, 0);
    checkOutput("t1 addr dropped", ram_address, 0);
    nextCycle(); #1;
    checkOutput("t1 rvalid0", rvalid0, 1);
    checkOutput("t1 rdata0", rdata0, 32'hC0DE_0010);
    checkOutput("t1 rvalid1", rvalid1, 0);
    checkOutput("t1 gnt0 released", gnt0, 0);
    nextCycle(); #1;
    checkOutput("t1 rvalid0 late", rvalid0, 0);

    // Round-robin alternation without lock
    $display("[TB] round robin");
    resetDut();
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 16'h0200, '0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 16'h0300, '0, 1'b0);
    #1;
    checkOutput("t2 gnt0 idle", gnt0, 0);
    for (int i = 1; i <= 6; i++) begin
      nextCycle(); #1;
      checkOutput($sformatf("t2 gnt0 c%0d", i), gnt0, (i % 2 == 1));
      checkOutput($sformatf("t2 gnt1 c%0d", i), gnt1, (i % 2 == 0));
      checkOutput($sformatf("t2 addr c%0d", i), ram_address, (i % 2 == 1) ? 32'h0200 : 32'h0300);
      checkOutput($sformatf("t2 rvalid0 c%0d", i), rvalid0, (i >= 3 && i % 2 == 1));
      checkOutput($sformatf("t2 rvalid1 c%0d", i), rvalid1, (i >= 3 && i % 2 == 0));
      if (i >= 3 && i % 2 == 1) checkOutput($sformatf("t2 rdata0 c%0d", i), rdata0, 32'hC0DE_0200);
      if (i >= 3 && i % 2 == 0) checkOutput($sformatf("t2 rdata1 c%0d", i), rdata1, 32'hC0DE_0300);
    end
    idleAll();
    repeat (4) nextCycle();

    // Locked burst limited to 16 accesses
    $display("[TB] locked burst");
    resetDut();
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 16'h0400, '0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 16'h0500, '0, 1'b0);
    #1;
    checkOutput("t3 gnt0 idle", gnt0, 0);
    for (int i = 1; i <= 18; i++) begin
      nextCycle(); #1;
      checkOutput($sformatf("t3 gnt0 c%0d", i), gnt0, (i <= 16 || i == 18));
      checkOutput($sformatf("t3 gnt1 c%0d", i), gnt1, (i == 17));
    end
    idleAll();
    repeat (4) nextCycle();

    // Write by requester 0, then read-back by requester 1 across an ownership switch
    $display("[TB] write then read");
    resetDut();
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 16'h0100, 32'hDEAD_BEEF, 1'b1);
    #1;
    checkOutput("t4 wren idle", ram_wren, 0);
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 16'h0100, '0, 1'b0);
    #1;
    checkOutput("t4 gnt0", gnt0, 1);
    checkOutput("t4 wren", ram_wren, 1);
    checkOutput("t4 addr", ram_address, 32'h0100);
    checkOutput("t4 data", ram_data, 32'hDEAD_BEEF);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    checkOutput("t4 gnt1", gnt1, 1);
    checkOutput("t4 wren after", ram_wren, 0);
    checkOutput("t4 addr read", ram_address, 32'h0100);
    checkOutput("t4 data read", ram_data, 0);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 16'h0600, '0, 1'b0);
    #1;
    checkOutput("t4 rvalid1 early", rvalid1, 0);
    checkOutput("t4 rvalid0 write", rvalid0, 0);
    nextCycle(); #1;
    checkOutput("t4 gnt0 switch", gnt0, 1);
    checkOutput("t4 rvalid1", rvalid1, 1);
    checkOutput("t4 rdata1", rdata1, 32'hDEAD_BEEF);
    checkOutput("t4 rvalid0 none", rvalid0, 0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    checkOutput("t4 rvalid1 once", rvalid1, 0);
    checkOutput("t4 rvalid0 gap", rvalid0, 0);
    nextCycle(); #1;
    checkOutput("t4 rvalid0", rvalid0, 1);
    checkOutput("t4 rdata0", rdata0, 32'hC0DE_0600);
    repeat (3) nextCycle();

    // Reset with two reads in flight
    $display("[TB] reset mid-burst");
    applyStimulus(0, 1'b1, 1'b0, 16'h0700, '0, 1'b0);
    nextCycle(); #1;
    checkOutput("t5 gnt0 c1", gnt0, 1);
    checkOutput("t5 addr c1", ram_address, 32'h0700);
    nextCycle(); #1;
    checkOutput("t5 gnt0 c2", gnt0, 1);
    #1;
    reset_sink_reset_n = 1'b0;
    #1;
    checkOutput("t5 gnt0 rst", gnt0, 0);
    checkOutput("t5 gnt1 rst", gnt1, 0);
    checkOutput("t5 rvalid0 rst", rvalid0, 0);
    checkOutput("t5 rvalid1 rst", rvalid1, 0);
    checkOutput("t5 wren rst", ram_wren, 0);
    checkOutput("t5 addr rst", ram_address, 0);
    idleAll();
    repeat (2) nextCycle();
    reset_sink_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nextCycle(); #1;
      checkOutput($sformatf("t5 rvalid0 post c%0d", i), rvalid0, 0);
      checkOutput($sformatf("t5 rvalid1 post c%0d", i), rvalid1, 0);
    end

    // Requester 0 locked, then requester 1 rises
    $display("[TB] lock vs late requester");
    resetDut();
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 16'h0800, 32'h1111_0000, 1'b1);
    #1;
    checkOutput("t6 gnt0 idle", gnt0, 0);
    nextCycle(); #1;
    checkOutput("t6 gnt0 c1", gnt0, 1);
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 16'h0900, 32'h2222_0000, 1'b1);
    #1;
    checkOutput("t6 gnt0 c2", gnt0, 1);
    checkOutput("t6 gnt1 c2", gnt1, 0);
`ifdef SCANOUT_PRIORITY_EN
    nextCycle(); #1;
    checkOutput("t6 gnt1 c3", gnt1, 1);
    checkOutput("t6 gnt0 c3", gnt0, 0);
    nextCycle(); #1;
    checkOutput("t6 gnt1 c4", gnt1, 1);
    checkOutput("t6 gnt0 c4", gnt0, 0);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    checkOutput("t6 gnt1 c5", gnt1, 1);
    nextCycle(); #1;
    checkOutput("t6 gnt0 c6", gnt0, 1);
    checkOutput("t6 gnt1 c6", gnt1, 0);
`else
    nextCycle(); #1;
    checkOutput("t6 gnt0 c3", gnt0, 1);
    checkOutput("t6 gnt1 c3", gnt1, 0);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    checkOutput("t6 gnt0 c4", gnt0, 1);
    repeat (20) nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 16'h0900, 32'h2222_0000, 1'b1);
    #1;
    checkOutput("t6 gnt0 sat", gnt0, 1);
    checkOutput("t6 gnt1 sat", gnt1, 0);
    nextCycle(); #1;
    checkOutput("t6 gnt1 after sat", gnt1, 1);
    checkOutput("t6 gnt0 after sat", gnt0, 0);
`endif
    idleAll();
    repeat (3) nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
